// File: rtl/hex_keypad_entry_if.sv
// hex_keypad_entry_if: keypad matrix lines and entered-value outputs of the keypad entry block
interface hex_keypad_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear;
    logic [15:0] data;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    modport master (input row, clear, output col, data, key_code, key_valid, key_held);
    modport slave (output row, clear, input col, data, key_code, key_valid, key_held);
endinterface

// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans a 4x4 hex keypad, debounces presses and shifts accepted codes into a 16-bit value
module hex_keypad_entry #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input logic                clk,
    input logic                rst_n,
    hex_keypad_entry_if.master bus
);
    localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // nibble index is {row, column}; rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
    state_t        state, state_n;
    logic [3:0]    rs_meta, rs;
    logic [3:0]    pat, pat_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [1:0]    row_idx;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   data, data_n;
    logic [3:0]    key_code, key_code_n;
    logic [3:0]    code;
    logic          key_valid, key_valid_n;
    logic          key_held, key_held_n;
    logic          match;
    assign match = rs == pat;
    assign row_idx = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
    assign code = KEYMAP[{row_idx, col_idx, 2'b00} +: 4];
    assign bus.col = ~(4'b0001 << col_idx);
    assign bus.data = data;
    assign bus.key_code = key_code;
    assign bus.key_valid = key_valid;
    assign bus.key_held = key_held;
    // two-flop synchroniser for the asynchronous row lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_meta <= 4'b1111;
            rs <= 4'b1111;
        end else begin
            rs_meta <= bus.row;
            rs <= rs_meta;
        end
    end
    // state register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCAN;
            col_idx <= 2'd0;
            cnt <= '0;
            pat <= 4'b1111;
            data <= 16'h0000;
            key_code <= 4'h0;
            key_valid <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state <= state_n;
            col_idx <= col_idx_n;
            cnt <= cnt_n;
            pat <= pat_n;
            data <= data_n;
            key_code <= key_code_n;
            key_valid <= key_valid_n;
            key_held <= key_held_n;
        end
    end
    // scan, debounce, hold and release sequencing; clear overrides the shift on the same edge
    always_comb begin
        state_n = state;
        col_idx_n = col_idx;
        cnt_n = cnt;
        pat_n = pat;
        data_n = data;
        key_code_n = key_code;
        key_valid_n = 1'b0;
        key_held_n = key_held;
        case (state)
            SCAN: begin
                if (cnt != SCAN_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else if ($onehot(~rs)) begin
                    state_n = DEBOUNCE;
                    pat_n = rs;
                    cnt_n = '0;
                end else begin
                    col_idx_n = col_idx + 2'd1;
                    cnt_n = '0;
                end
            end
            DEBOUNCE: begin
                if (!match) begin
                    state_n = SCAN;
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = PRESSED;
                    cnt_n = '0;
                    key_valid_n = 1'b1;
                    key_code_n = code;
                    key_held_n = 1'b1;
                    data_n = {data[11:0], code};
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!match) begin
                    state_n = RELEASE;
                    cnt_n = '0;
                end
            end
            RELEASE: begin
                if (match) begin
                    state_n = PRESSED;
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = SCAN;
                    cnt_n = '0;
                    key_held_n = 1'b0;
                    col_idx_n = col_idx + 2'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
        if (bus.clear) data_n = 16'h0000;
    end
endmodule
